// File: rtl/ce_ls_multi.sv
// LS channel estimate: each RX lane is multiplied by the conjugate of a shared RS coefficient, or passed through.
// Three-stage valid/ready pipeline with 3 clk latency and 1 beat/clk; a stalled output holds every source_* stable.
module ce_ls_multi #(
  parameter int wDataIn  = 16,
  parameter int wCoeff   = 18,
  parameter int wDataOut = 16,
  parameter int nChan    = 2,
  parameter int SHIFT    = 17
) (
  input  logic                      clk,
  input  logic                      rst_n_sync,
  input  logic                      mode,
  input  logic                      sink_valid,
  input  logic                      sink_sop,
  input  logic                      sink_eop,
  output logic                      sink_ready,
  input  logic [nChan*wDataIn-1:0]  sink_real,
  input  logic [nChan*wDataIn-1:0]  sink_imag,
  input  logic [wCoeff-1:0]         coeff_real,
  input  logic [wCoeff-1:0]         coeff_imag,
  input  logic [11:0]               fftpts_in,
  output logic                      source_valid,
  output logic                      source_sop,
  output logic                      source_eop,
  input  logic                      source_ready,
  output logic [nChan*wDataOut-1:0] source_real,
  output logic [nChan*wDataOut-1:0] source_imag,
  output logic [1:0]                source_error
);

  localparam int PW = wDataIn + wCoeff;
  localparam int FW = PW + 1;
  localparam int RW = FW + 1;
  localparam logic signed [RW-1:0] RND  = {{(RW-1){1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [RW-1:0] OMAX = {{(RW-wDataOut+1){1'b0}}, {(wDataOut-1){1'b1}}};
  localparam logic signed [RW-1:0] OMIN = {{(RW-wDataOut+1){1'b1}}, {(wDataOut-1){1'b0}}};

  function automatic logic [wDataOut-1:0] sat_out(input logic signed [RW-1:0] v);
    if (v > OMAX) return OMAX[wDataOut-1:0];
    if (v < OMIN) return OMIN[wDataOut-1:0];
    return v[wDataOut-1:0];
  endfunction

  logic        rdy_q;
  logic [11:0] cnt_q, cnt_d;
  logic        open_q, open_d;
  logic        mode_hold_q, mode_hold_d;
  logic        beat_mode;
  logic [1:0]  beat_err;
  logic        sink_xfer;

  logic                       s1_vld_q, s1_sop_q, s1_eop_q, s1_mode_q;
  logic [1:0]                 s1_err_q;
  logic [nChan*wDataIn-1:0]   s1_re_q, s1_im_q;
  logic signed [wCoeff-1:0]   s1_cr_q, s1_ci_q;
  logic                       s2_vld_q, s2_sop_q, s2_eop_q, s2_mode_q;
  logic [1:0]                 s2_err_q;
  logic                       s3_vld_q, s3_sop_q, s3_eop_q;
  logic [1:0]                 s3_err_q;
  logic                       s1_free, s2_free, s3_free, s2_ld, s3_ld;

  assign s3_free    = ~s3_vld_q | source_ready;
  assign s2_free    = ~s2_vld_q | s3_free;
  assign s1_free    = ~s1_vld_q | s2_free;
  assign s2_ld      = s2_free & s1_vld_q;
  assign s3_ld      = s3_free & s2_vld_q;
  assign sink_ready = rdy_q & s1_free;
  assign sink_xfer  = sink_valid & sink_ready;

  // Frame tracking runs at the sink so the status travels down the pipe with its beat.
  always_comb begin
    cnt_d       = cnt_q;
    open_d      = open_q;
    mode_hold_d = mode_hold_q;
    beat_mode   = mode_hold_q;
    beat_err    = 2'b00;
    if (sink_xfer) begin
      if (sink_sop) begin
        cnt_d       = 12'd1;
        open_d      = 1'b1;
        mode_hold_d = mode;
        beat_mode   = mode;
      end else if (cnt_q != 12'hFFF) begin
        cnt_d = cnt_q + 12'd1;
      end
      if (sink_eop) begin
        open_d = 1'b0;
        if (!sink_sop && !open_q)  beat_err = 2'b10;
        else if (cnt_d != fftpts_in) beat_err = 2'b01;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      rdy_q       <= 1'b0;
      cnt_q       <= '0;
      open_q      <= 1'b0;
      mode_hold_q <= 1'b0;
    end else begin
      rdy_q       <= 1'b1;
      cnt_q       <= cnt_d;
      open_q      <= open_d;
      mode_hold_q <= mode_hold_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      s1_vld_q <= 1'b0; s1_sop_q <= 1'b0; s1_eop_q <= 1'b0; s1_mode_q <= 1'b0;
      s1_err_q <= '0;   s1_re_q  <= '0;   s1_im_q  <= '0;
      s1_cr_q  <= '0;   s1_ci_q  <= '0;
      s2_vld_q <= 1'b0; s2_sop_q <= 1'b0; s2_eop_q <= 1'b0; s2_mode_q <= 1'b0;
      s2_err_q <= '0;
      s3_vld_q <= 1'b0; s3_sop_q <= 1'b0; s3_eop_q <= 1'b0; s3_err_q  <= '0;
    end else begin
      if (s1_free) s1_vld_q <= sink_xfer;
      if (sink_xfer) begin
        s1_sop_q  <= sink_sop;
        s1_eop_q  <= sink_eop;
        s1_mode_q <= beat_mode;
        s1_err_q  <= beat_err;
        s1_re_q   <= sink_real;
        s1_im_q   <= sink_imag;
        s1_cr_q   <= coeff_real;
        s1_ci_q   <= coeff_imag;
      end
      if (s2_free) s2_vld_q <= s1_vld_q;
      if (s2_ld) begin
        s2_sop_q  <= s1_sop_q;
        s2_eop_q  <= s1_eop_q;
        s2_mode_q <= s1_mode_q;
        s2_err_q  <= s1_err_q;
      end
      if (s3_free) s3_vld_q <= s2_vld_q;
      if (s3_ld) begin
        s3_sop_q <= s2_sop_q;
        s3_eop_q <= s2_eop_q;
        s3_err_q <= s2_err_q;
      end
    end
  end

  assign source_valid = s3_vld_q;
  assign source_sop   = s3_sop_q;
  assign source_eop   = s3_eop_q;
  assign source_error = s3_err_q;

  for (genvar k = 0; k < nChan; k++) begin : g_lane
    logic signed [wDataIn-1:0] sr, si;
    logic signed [PW-1:0]      a_d, b_d, c_d, d_d;
    logic signed [PW-1:0]      a_q, b_q, c_q, d_q;
    logic signed [RW-1:0]      re_full, im_full, re_sh, im_sh;
    logic [wDataOut-1:0]       re_q, im_q;

    assign sr = s1_re_q[k*wDataIn +: wDataIn];
    assign si = s1_im_q[k*wDataIn +: wDataIn];

    // Bypass reuses the product registers with the zero terms, so the latency is identical.
    always_comb begin
      if (s1_mode_q) begin
        a_d = PW'(sr);
        b_d = '0;
        c_d = PW'(si);
        d_d = '0;
      end else begin
        a_d = PW'(sr) * PW'(s1_cr_q);
        b_d = PW'(si) * PW'(s1_ci_q);
        c_d = PW'(si) * PW'(s1_cr_q);
        d_d = PW'(sr) * PW'(s1_ci_q);
      end
    end

    assign re_full = RW'(a_q) + RW'(b_q);
    assign im_full = RW'(c_q) - RW'(d_q);
    assign re_sh   = s2_mode_q ? re_full : ((re_full + RND) >>> SHIFT);
    assign im_sh   = s2_mode_q ? im_full : ((im_full + RND) >>> SHIFT);

    always_ff @(posedge clk or negedge rst_n_sync) begin
      if (!rst_n_sync) begin
        a_q  <= '0;
        b_q  <= '0;
        c_q  <= '0;
        d_q  <= '0;
        re_q <= '0;
        im_q <= '0;
      end else begin
        if (s2_ld) begin
          a_q <= a_d;
          b_q <= b_d;
          c_q <= c_d;
          d_q <= d_d;
        end
        if (s3_ld) begin
          re_q <= sat_out(re_sh);
          im_q <= sat_out(im_sh);
        end
      end
    end

    assign source_real[k*wDataOut +: wDataOut] = re_q;
    assign source_imag[k*wDataOut +: wDataOut] = im_q;
  end

endmodule

// File: tb/tb_ce_ls_multi.sv
// Directed bench for ce_ls_multi: hand-computed vector table plus frame, backpressure and reset sequences.
module tb_ce_ls_multi;

  logic        clk = 1'b0;
  logic        rst_n_sync;
  logic        mode;
  logic        sink_valid, sink_sop, sink_eop, sink_ready;
  logic [31:0] sink_real, sink_imag;
  logic [17:0] coeff_real, coeff_imag;
  logic [11:0] fftpts_in;
  logic        source_valid, source_sop, source_eop, source_ready;
  logic [31:0] source_real, source_imag;
  logic [1:0]  source_error;

  always #5 clk = ~clk;

  ce_ls_multi dut (
    .clk(clk), .rst_n_sync(rst_n_sync), .mode(mode),
    .sink_valid(sink_valid), .sink_sop(sink_sop), .sink_eop(sink_eop), .sink_ready(sink_ready),
    .sink_real(sink_real), .sink_imag(sink_imag),
    .coeff_real(coeff_real), .coeff_imag(coeff_imag), .fftpts_in(fftpts_in),
    .source_valid(source_valid), .source_sop(source_sop), .source_eop(source_eop),
    .source_ready(source_ready), .source_real(source_real), .source_imag(source_imag),
    .source_error(source_error)
  );

  typedef struct {
    int r0, i0, r1, i1, sop, eop, err;
  } out_t;

  typedef struct {
    int md, sp, ep;
    int sr0, si0, sr1, si1, cr, ci, fft;
    int er0, ei0, er1, ei1, eerr;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   stab_viol = 0;
  bit   stall_prev = 1'b0;
  bit   rnd_en = 1'b0;
  out_t held;
  out_t got[$];
  out_t exp_q[$];
  vec_t tbl[11];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic out_t cur_out();
    out_t c;
    c.r0  = int'($signed(source_real[15:0]));
    c.i0  = int'($signed(source_imag[15:0]));
    c.r1  = int'($signed(source_real[31:16]));
    c.i1  = int'($signed(source_imag[31:16]));
    c.sop = int'(source_sop);
    c.eop = int'(source_eop);
    c.err = int'(source_error);
    return c;
  endfunction

  function automatic bit same(input out_t a, input out_t b);
    return a.r0 == b.r0 && a.i0 == b.i0 && a.r1 == b.r1 && a.i1 == b.i1 &&
           a.sop == b.sop && a.eop == b.eop && a.err == b.err;
  endfunction

  function automatic int sat16(input longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  // Reference: conj multiply, round half up by 2^16, floor shift by 17, clamp.
  function automatic int ls_re(input int sr, input int si, input int cr, input int ci);
    longint s;
    s = longint'(sr) * longint'(cr) + longint'(si) * longint'(ci);
    return sat16((s + 64'sd65536) >>> 17);
  endfunction

  function automatic int ls_im(input int sr, input int si, input int cr, input int ci);
    longint s;
    s = longint'(si) * longint'(cr) - longint'(sr) * longint'(ci);
    return sat16((s + 64'sd65536) >>> 17);
  endfunction

  // Output monitor: records accepted beats and flags any change while stalled.
  always @(negedge clk) begin
    out_t c;
    c = cur_out();
    if (stall_prev && (!source_valid || !same(c, held))) stab_viol++;
    stall_prev = source_valid && !source_ready && rst_n_sync;
    held = c;
    if (source_valid && source_ready) got.push_back(c);
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_en) source_ready = ($urandom_range(0, 1) != 0);
  end

  // Caller sits 1 time unit after a rising edge; returns likewise, one beat later.
  task automatic send(input int md, input int sp, input int ep, input int sr0, input int si0,
                      input int sr1, input int si1, input int cr, input int ci, input int fft);
    int guard;
    mode       = (md != 0);
    sink_sop   = (sp != 0);
    sink_eop   = (ep != 0);
    sink_real  = {sr1[15:0], sr0[15:0]};
    sink_imag  = {si1[15:0], si0[15:0]};
    coeff_real = cr[17:0];
    coeff_imag = ci[17:0];
    fftpts_in  = fft[11:0];
    sink_valid = 1'b1;
    guard = 0;
    forever begin
      @(negedge clk);
      if (sink_ready) break;
      guard++;
      if (guard > 1000) begin
        check("sink_ready_timeout", 0, 1);
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    sink_valid = 1'b0;
  endtask

  task automatic wait_drain(input int n);
    int g;
    g = 0;
    while (got.size() < n && g < 10000) begin
      @(posedge clk);
      g++;
    end
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic stream(input int n, input int fft, input int exp_err, input string tag);
    int   cr, ci, sr0, si0, sr1, si1, mism;
    out_t e;
    got.delete();
    exp_q.delete();
    cr = int'($urandom_range(0, 262143)) - 131072;
    ci = int'($urandom_range(0, 262143)) - 131072;
    for (int i = 0; i < n; i++) begin
      sr0 = int'($urandom_range(0, 65535)) - 32768;
      si0 = int'($urandom_range(0, 65535)) - 32768;
      sr1 = int'($urandom_range(0, 65535)) - 32768;
      si1 = int'($urandom_range(0, 65535)) - 32768;
      e.r0  = ls_re(sr0, si0, cr, ci);
      e.i0  = ls_im(sr0, si0, cr, ci);
      e.r1  = ls_re(sr1, si1, cr, ci);
      e.i1  = ls_im(sr1, si1, cr, ci);
      e.sop = (i == 0) ? 1 : 0;
      e.eop = (i == n - 1) ? 1 : 0;
      e.err = (i == n - 1) ? exp_err : 0;
      exp_q.push_back(e);
      send(0, e.sop, e.eop, sr0, si0, sr1, si1, cr, ci, fft);
    end
    wait_drain(n);
    check({tag, "_len"}, got.size(), n);
    mism = 0;
    for (int i = 0; i < n && i < got.size(); i++)
      if (!same(got[i], exp_q[i])) mism++;
    check({tag, "_data_mismatches"}, mism, 0);
    check({tag, "_eop_err"}, (got.size() > 0) ? got[got.size()-1].err : -1, exp_err);
  endtask

  initial begin
    int   lat;
    out_t g;
    out_t bad;
    bad = '{-99, -99, -99, -99, -99, -99, -99};

    //        md sp ep   sr0    si0    sr1    si1     cr      ci   fft   r0     i0     r1     i1   err
    tbl[0]  = '{0, 1, 1,  1000,  -500, -1000,   500,  65536,      0, 1,   500,  -250,  -500,  250, 0};
    tbl[1]  = '{0, 1, 1, 32767, 32767, -32768, -32768, 131071, 131071, 1, 32767,     0, -32768,   0, 0};
    tbl[2]  = '{0, 1, 0,   100,   200,     3,    -7,      0,  65536, 3,   100,   -50,    -3,   -1, 0};
    tbl[3]  = '{1, 0, 0,     1,     1,     3,    -3, -65536,      0, 3,     0,     0,    -1,    2, 0};
    tbl[4]  = '{1, 0, 1,     2,     2,     0,     0,  65536,      0, 3,     1,     1,     0,    0, 0};
    tbl[5]  = '{1, 1, 1, -12345, 32767, -32768,    7,  65536,      0, 2, -12345, 32767, -32768,   7, 1};
    tbl[6]  = '{1, 0, 1,     5,    -5,     0,     0,  65536,      0, 2,     5,    -5,     0,    0, 2};
    tbl[7]  = '{0, 1, 1,    -1,    -1,    -2,     1,  65536,      0, 1,     0,     0,    -1,    1, 0};
    tbl[8]  = '{0, 1, 0,     4,     6,     0,     0,  65536,      0, 2,     2,     3,     0,    0, 0};
    tbl[9]  = '{0, 1, 0,     0,     0,     0,     0,  65536,      0, 2,     0,     0,     0,    0, 0};
    tbl[10] = '{0, 0, 1,     0,     0,     0,     0,  65536,      0, 2,     0,     0,     0,    0, 0};

    rst_n_sync = 1'b1; mode = 1'b0; sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
    sink_real = '0; sink_imag = '0; coeff_real = '0; coeff_imag = '0; fftpts_in = '0;
    source_ready = 1'b1;
    #2 rst_n_sync = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sink_ready",   int'(sink_ready), 0);
    check("rst_source_valid", int'(source_valid), 0);
    check("rst_source_real",  int'(source_real), 0);
    check("rst_source_imag",  int'(source_imag), 0);
    check("rst_source_error", int'(source_error), 0);
    @(posedge clk);
    #1 rst_n_sync = 1'b1;
    #1 check("release_ready_before_edge", int'(sink_ready), 0);
    @(posedge clk);
    #1 check("release_ready_after_edge", int'(sink_ready), 1);

    // Latency: the transfer edge counts as clock 1.
    got.delete();
    mode = 1'b0; sink_sop = 1'b1; sink_eop = 1'b1; fftpts_in = 12'd1;
    sink_real = {16'hFC18, 16'd1000}; sink_imag = {16'd500, 16'hFE0C};
    coeff_real = 18'd65536; coeff_imag = '0; sink_valid = 1'b1;
    @(negedge clk);
    check("lat_sink_ready", int'(sink_ready), 1);
    @(posedge clk);
    #1 sink_valid = 1'b0;
    lat = 1;
    while (!source_valid && lat < 10) begin
      @(posedge clk);
      #1 lat++;
    end
    check("latency_clks", lat, 3);
    wait_drain(1);
    g = (got.size() > 0) ? got[0] : bad;
    check("lat_lane0_real", g.r0, 500);
    check("lat_lane0_imag", g.i0, -250);

    // Vector table, streamed back to back.
    got.delete();
    for (int i = 0; i < 11; i++)
      send(tbl[i].md, tbl[i].sp, tbl[i].ep, tbl[i].sr0, tbl[i].si0, tbl[i].sr1, tbl[i].si1,
           tbl[i].cr, tbl[i].ci, tbl[i].fft);
    wait_drain(11);
    check("table_len", got.size(), 11);
    for (int i = 0; i < 11; i++) begin
      g = (i < got.size()) ? got[i] : bad;
      check($sformatf("v%0d_r0", i),  g.r0,  tbl[i].er0);
      check($sformatf("v%0d_i0", i),  g.i0,  tbl[i].ei0);
      check($sformatf("v%0d_r1", i),  g.r1,  tbl[i].er1);
      check($sformatf("v%0d_i1", i),  g.i1,  tbl[i].ei1);
      check($sformatf("v%0d_sop", i), g.sop, tbl[i].sp);
      check($sformatf("v%0d_eop", i), g.eop, tbl[i].ep);
      check($sformatf("v%0d_err", i), g.err, tbl[i].eerr);
    end

    stream(1200, 1200, 0, "frame1200");
    stream(1199, 1200, 1, "frame1199");

    stab_viol = 0;
    rnd_en = 1'b1;
    stream(1200, 1200, 0, "rnd_ready");
    rnd_en = 1'b0;
    @(posedge clk);
    #2 source_ready = 1'b1;
    check("stall_outputs_stable", stab_viol, 0);

    // Reset with three beats in flight.
    repeat (4) @(posedge clk);
    #1 got.delete();
    send(0, 1, 0, 10, 20, 30, 40, 65536, 0, 10);
    send(0, 0, 0, 11, 21, 31, 41, 65536, 0, 10);
    send(0, 0, 0, 12, 22, 32, 42, 65536, 0, 10);
    rst_n_sync = 1'b0;
    #1;
    check("midrst_source_valid", int'(source_valid), 0);
    check("midrst_source_sop",   int'(source_sop), 0);
    check("midrst_source_real",  int'(source_real), 0);
    check("midrst_source_imag",  int'(source_imag), 0);
    check("midrst_sink_ready",   int'(sink_ready), 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n_sync = 1'b1;
    repeat (4) @(posedge clk);
    #1 check("postrst_no_stale", got.size(), 0);
    send(0, 0, 1, 7, 7, 7, 7, 65536, 0, 10);
    wait_drain(1);
    check("postrst_len", got.size(), 1);
    g = (got.size() > 0) ? got[0] : bad;
    check("postrst_err", g.err, 2);
    check("postrst_r0", g.r0, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ce_ls_multi.md
CE_LS_MULTI -- requirements
Module: ce_ls_multi

Interface
REQ-001 Parameter wDataIn, default 16: signed width of sink_real/sink_imag per channel.
REQ-002 Parameter wCoeff, default 18: signed width of RS coefficient per component.
REQ-003 Parameter wDataOut, default 16: signed width of source_real/source_imag per channel.
REQ-004 Parameter nChan, default 2: number of parallel RX-antenna lanes sharing one coefficient.
REQ-005 Parameter SHIFT, default 17: right shift applied after multiply-accumulate.
REQ-006 Ports, in order:
- clk  in  1  sole clock.
- rst_n_sync  in  1  reset, asynchronous assert, active-low.
- mode  in  1  0 = LS conjugate multiply, 1 = bypass.
- sink_valid, sink_sop, sink_eop  in  1 each  input handshake and framing.
- sink_ready  out  1  input accept.
- sink_real, sink_imag  in  nChan*wDataIn each  lane k at bits [k*wDataIn +: wDataIn].
- coeff_real, coeff_imag  in  wCoeff each  RS tx value, same beat as sink data.
- fftpts_in  in  12  expected samples per frame.
- source_valid, source_sop, source_eop  out  1 each  output handshake and framing.
- source_ready  in  1  downstream accept.
- source_real, source_imag  out  nChan*wDataOut each  lane packing as for sink.
- source_error  out  2  frame status, on the eop beat only.

Function
REQ-007 Transfer occurs on a rising clk edge where valid=1 and ready=1; this rule applies on both sides.
REQ-008 Three-stage pipeline (S1 input register, S2 products, S3 sum/round/saturate = output register); latency 3 clk from sink transfer to source_valid when source_ready is held high.
REQ-009 Each stage loads when it is empty or its content is leaving; sink_ready = ~S1_valid | S1_advance; full throughput (1 beat/clk) with no bubbles while source_ready=1.
REQ-010 source_valid=1 with source_ready=0: all source_* outputs hold stable; no beat is dropped or duplicated.
REQ-011 LS mode, per lane: real = sr*cr + si*ci; imag = si*cr - sr*ci; full precision wDataIn+wCoeff+1 bits.
REQ-012 Rounding: add 2^(SHIFT-1), then arithmetic shift right by SHIFT (round half up).
REQ-013 Saturation: clamp the result to [-2^(wDataOut-1), 2^(wDataOut-1)-1].
REQ-014 Bypass mode: input sign-extended or saturated to wDataOut; no multiply; same 3-clk latency.
REQ-015 mode is sampled on the sop transfer and held for the whole frame; changes mid-frame are ignored.
REQ-016 A 12-bit frame counter clears to 1 on a sop transfer and increments on each non-sop transfer.
REQ-017 Beat with sop and eop both set is a frame of length 1.
REQ-018 source_error on the eop beat: 2'b00 if counter == fftpts_in; 2'b01 if count mismatch; 2'b10 if eop arrived with no open frame (no sop since the last eop). 2'b10 has priority over 2'b01.
REQ-019 source_error = 2'b00 on all non-eop beats.
REQ-020 sop while a frame is open: restart the count; the previous frame reports no error (it has no eop).
REQ-021 Counter saturates at 4095 (no wrap).
REQ-022 sop/eop propagate with their data beat.

Reset
REQ-023 With rst_n_sync=0, asynchronously: all stage valids = 0, and source_valid, source_sop, source_eop, source_error, source_real and source_imag = 0.
REQ-024 During reset, sink_ready = 0; frame counter = 0, frame-open flag = 0, held mode = 0.
REQ-025 Reset mid-frame discards all in-flight beats; the first post-reset frame requires a new sop.
REQ-026 Release is synchronised to clk; sink_ready rises on the first clk edge after release.

Verification (defaults, nChan=2)
REQ-027 Coeff 65536+j0, lane0 input 1000-j500, mode=0 -> lane0 output 500-j250, exactly 3 clk after the sink transfer.
REQ-028 Coeff 131071+j131071, input 32767+j32767 -> real 32767 (saturated), imag 0.
REQ-029 fftpts_in=1200, 1200-beat frame with sop/eop -> error 00 on the eop; 1199-beat frame -> error 01.
REQ-030 eop sent without a preceding sop -> error 10 on that beat.
REQ-031 Random source_ready toggling over a 1200-beat frame -> output sequence equals the reference model, no loss or duplication; outputs stable while stalled.
REQ-032 Reset asserted mid-frame with 3 beats in flight -> outputs go to 0 immediately; after release, no stale beats are emitted.
